// File: rtl/lif_pkg.sv
// -----------------------------------------------------------------------------
// lif_pkg
// Shared definitions for the time-multiplexed leaky integrate-and-fire (LIF)
// neuron designs: the scheduler FSM state type, the datapath widths and the
// default neuron parameters.
// -----------------------------------------------------------------------------
package lif_pkg;

    // Membrane state, stimulus and refractory counter widths
    localparam int DATA_W = 8;
    localparam int REFR_W = 8;

    // Default neuron behaviour
    localparam int DEF_THRESHOLD     = 200;
    localparam int DEF_DECAY_SHIFT   = 1;
    localparam int DEF_REFRACT_TICKS = 2;

    // Sweep scheduler states
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_UPDATE = 2'd2,
        S_DONE   = 2'd3
    } lif_state_e;

endpackage

// File: rtl/lif_update.sv
// -----------------------------------------------------------------------------
// lif_update
// Combinational LIF neuron update: leak, stimulus integration and threshold.
//   sum = (state - (state >> DECAY_SHIFT)) + eff_stim   (DATA_W+1 bits)
//   eff_stim is forced to 0 while the neuron is refractory.
// Ports:
//   state      : current membrane state
//   stim       : stimulus register of this neuron
//   refractory : high while the neuron's refractory counter is nonzero
//   fire       : sum reached THRESHOLD
//   next_state : 0 when firing, otherwise sum[DATA_W-1:0]
// -----------------------------------------------------------------------------
module lif_update
    import lif_pkg::*;
#(
    parameter int THRESHOLD   = DEF_THRESHOLD,
    parameter int DECAY_SHIFT = DEF_DECAY_SHIFT
) (
    input  logic [DATA_W-1:0] state,
    input  logic [DATA_W-1:0] stim,
    input  logic              refractory,
    output logic              fire,
    output logic [DATA_W-1:0] next_state
);

    localparam logic [DATA_W:0] THRESH = (DATA_W + 1)'(THRESHOLD);

    // Leak never underflows: the shifted term is at most the state itself.
    function automatic logic [DATA_W-1:0] leak(input logic [DATA_W-1:0] s);
        return s - (s >> DECAY_SHIFT);
    endfunction

    logic [DATA_W-1:0] eff_stim;
    logic [DATA_W:0]   sum;

    always_comb begin
        eff_stim   = refractory ? '0 : stim;
        sum        = {1'b0, leak(state)} + {1'b0, eff_stim};
        fire       = (sum >= THRESH);
        next_state = fire ? '0 : sum[DATA_W-1:0];
    end

endmodule

// File: rtl/lif_scheduler.sv
// -----------------------------------------------------------------------------
// lif_scheduler
// N_NEURONS virtual LIF neurons sharing one lif_update datapath. Each tick
// starts a sweep: every neuron gets one LOAD cycle (read its state, stimulus
// and refractory counter) and one UPDATE cycle (write back), then DONE
// publishes all spike bits at once. Sweep length: 2*N_NEURONS+1 cycles.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   tick            : request one sweep (one pending request is queued while
//                     busy; a further one sets the sticky overrun flag)
//   cfg_valid/ready : write cfg_data into the stimulus of neuron cfg_addr
//                     (ready only in IDLE)
//   sel, state_out  : registered readback of the membrane state of neuron sel
//   spike_vec       : spike bits of the last completed sweep
//   busy, done      : sweep in progress / one-cycle end-of-sweep pulse
//   overrun         : sticky, a tick was dropped
// -----------------------------------------------------------------------------
module lif_scheduler
    import lif_pkg::*;
#(
    parameter int N_NEURONS     = 4,
    parameter int THRESHOLD     = DEF_THRESHOLD,
    parameter int DECAY_SHIFT   = DEF_DECAY_SHIFT,
    parameter int REFRACT_TICKS = DEF_REFRACT_TICKS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [1:0]           cfg_addr,
    input  logic [7:0]           cfg_data,
    input  logic [1:0]           sel,
    output logic [7:0]           state_out,
    output logic [N_NEURONS-1:0] spike_vec,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun
);

    localparam int                IDX_W     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_NEURONS - 1);
    localparam logic [REFR_W-1:0] REFR_LOAD = REFR_W'(REFRACT_TICKS);

    lif_state_e       fsm_q, fsm_d;
    logic [IDX_W-1:0] idx_q;
    logic             pending_q, pending_d;
    logic             overrun_q;
    logic             ovr_set;
    logic             load_en, upd_en, cfg_we;

    logic [DATA_W-1:0]    state_mem [N_NEURONS];
    logic [DATA_W-1:0]    stim_mem  [N_NEURONS];
    logic [REFR_W-1:0]    refr_mem  [N_NEURONS];
    logic [N_NEURONS-1:0] spike_acc;

    logic [DATA_W-1:0] state_p0, stim_p0;
    logic [REFR_W-1:0] refr_p0;
    logic              upd_fire;
    logic [DATA_W-1:0] upd_state;

    logic [IDX_W-1:0] cfg_idx, sel_idx;

    assign cfg_idx = IDX_W'(cfg_addr);
    assign sel_idx = IDX_W'(sel);
    assign overrun = overrun_q;

    // Control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q     <= S_IDLE;
            idx_q     <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            pending_q <= pending_d;
            if (ovr_set) overrun_q <= 1'b1;
            if (upd_en) idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_comb begin
        fsm_d     = fsm_q;
        pending_d = pending_q;
        ovr_set   = 1'b0;
        cfg_ready = 1'b0;
        cfg_we    = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        load_en   = 1'b0;
        upd_en    = 1'b0;
        case (fsm_q)
            S_IDLE: begin
                busy      = 1'b0;
                cfg_ready = 1'b1;
                cfg_we    = cfg_valid;
                if (tick || pending_q) begin
                    fsm_d     = S_LOAD;
                    pending_d = 1'b0;
                end
            end
            S_LOAD: begin
                load_en = 1'b1;
                fsm_d   = S_UPDATE;
            end
            S_UPDATE: begin
                upd_en = 1'b1;
                fsm_d  = (idx_q == LAST_IDX) ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                done = 1'b1;
                fsm_d = pending_q ? S_LOAD : S_IDLE;
                // The queued tick is consumed here; a tick arriving now
                // becomes the new queued request.
                pending_d = tick;
            end
            default: fsm_d = S_IDLE;
        endcase
        if (tick && (fsm_q == S_LOAD || fsm_q == S_UPDATE)) begin
            if (pending_q) ovr_set   = 1'b1;
            else           pending_d = 1'b1;
        end
    end

    // Stage p0: operands of the neuron under update, captured in LOAD
    always_ff @(posedge clk) begin
        if (load_en) begin
            state_p0 <= state_mem[idx_q];
            stim_p0  <= stim_mem[idx_q];
            refr_p0  <= refr_mem[idx_q];
        end
    end

    lif_update #(
        .THRESHOLD   (THRESHOLD),
        .DECAY_SHIFT (DECAY_SHIFT)
    ) u_update (
        .state      (state_p0),
        .stim       (stim_p0),
        .refractory (refr_p0 != '0),
        .fire       (upd_fire),
        .next_state (upd_state)
    );

    // Stage p1: write-back in UPDATE, spike publish in DONE, readback
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                state_mem[i] <= '0;
                stim_mem[i]  <= '0;
                refr_mem[i]  <= '0;
            end
            spike_acc <= '0;
            spike_vec <= '0;
            state_out <= '0;
        end else begin
            if (cfg_we && (32'(cfg_addr) < N_NEURONS)) stim_mem[cfg_idx] <= cfg_data;
            if (upd_en) begin
                state_mem[idx_q] <= upd_state;
                spike_acc[idx_q] <= upd_fire;
                if (upd_fire)            refr_mem[idx_q] <= REFR_LOAD;
                else if (refr_p0 != '0)  refr_mem[idx_q] <= refr_p0 - REFR_W'(1);
            end
            if (done) spike_vec <= spike_acc;
            state_out <= (32'(sel) < N_NEURONS) ? state_mem[sel_idx] : '0;
        end
    end

endmodule

// File: tb/tb_lif_scheduler.sv
module tb_lif_scheduler;

    localparam int N  = 4;
    localparam int TH = 200;
    localparam int DS = 1;
    localparam int RT = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         tick = 1'b0;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic [1:0]   cfg_addr = '0;
    logic [7:0]   cfg_data = '0;
    logic [1:0]   sel = '0;
    logic [7:0]   state_out;
    logic [N-1:0] spike_vec;
    logic         busy, done, overrun;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: one entry per neuron
    int m_state [N];
    int m_stim  [N];
    int m_refr  [N];

    lif_scheduler #(
        .N_NEURONS     (N),
        .THRESHOLD     (TH),
        .DECAY_SHIFT   (DS),
        .REFRACT_TICKS (RT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .sel       (sel),
        .state_out (state_out),
        .spike_vec (spike_vec),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_state[i] = 0;
            m_stim[i]  = 0;
            m_refr[i]  = 0;
        end
    endfunction

    function automatic logic [N-1:0] model_sweep();
        logic [N-1:0] spk;
        spk = '0;
        for (int i = 0; i < N; i++) begin
            int leaked, eff, total;
            leaked = m_state[i] - m_state[i] / (2 ** DS);
            eff    = (m_refr[i] > 0) ? 0 : m_stim[i];
            total  = leaked + eff;
            if (total >= TH) begin
                m_state[i] = 0;
                spk[i]     = 1'b1;
                m_refr[i]  = RT;
            end else begin
                m_state[i] = total;
                if (m_refr[i] > 0) m_refr[i] = m_refr[i] - 1;
            end
        end
        return spk;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_data  = d;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    // Waits for done; cycles counts clock edges since the tick edge.
    task automatic wait_done(input int start, output int cycles, output bit timed_out);
        cycles    = start;
        timed_out = 1'b0;
        while (done !== 1'b1) begin
            if (cycles >= 40) begin
                timed_out = 1'b1;
                break;
            end
            step();
            cycles++;
        end
    endtask

    task automatic test_reset();
        tick = 1'b0;
        cfg_valid = 1'b0;
        do_reset();
        n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        n_cmp++; if (done !== 1'b0)      begin n_err++; $display("FAIL reset_done: got %b, expected 0", done); end
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL reset_cfg_ready: got %b, expected 1", cfg_ready); end
        n_cmp++; if (overrun !== 1'b0)   begin n_err++; $display("FAIL reset_overrun: got %b, expected 0", overrun); end
        n_cmp++; if (spike_vec !== '0)   begin n_err++; $display("FAIL reset_spike_vec: got %b, expected 0", spike_vec); end
        n_cmp++; if (state_out !== 8'd0) begin n_err++; $display("FAIL reset_state_out: got %0d, expected 0", state_out); end
    endtask

    task automatic test_charge_and_refractory();
        int  exp_st [11] = '{100, 150, 175, 188, 194, 197, 199, 0, 0, 0, 100};
        bit  exp_sp [11] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        int  cyc;
        bit  to;
        do_reset();
        sel = 2'd0;
        cfg_write(2'd0, 8'd100);
        for (int s = 0; s < 11; s++) begin
            pulse_tick();
            wait_done(1, cyc, to);
            n_cmp++; if (to || cyc != 9) begin n_err++; $display("FAIL charge_latency[%0d]: got %0d cycles (timeout %0d), expected 9", s, cyc, to); end
            step();
            n_cmp++; if (state_out !== 8'(exp_st[s])) begin n_err++; $display("FAIL charge_state[%0d]: got %0d, expected %0d", s, state_out, exp_st[s]); end
            n_cmp++; if (spike_vec[0] !== exp_sp[s])  begin n_err++; $display("FAIL charge_spike[%0d]: got %b, expected %b", s, spike_vec[0], exp_sp[s]); end
            step();
            step();
        end
    endtask

    task automatic test_cfg_same_cycle();
        int cyc;
        int ready_viol;
        bit to;
        do_reset();
        tick      = 1'b1;
        cfg_valid = 1'b1;
        cfg_addr  = 2'd2;
        cfg_data  = 8'd255;
        step();
        tick = 1'b0;
        // Keep offering a write to neuron 1 while busy; it must be refused.
        cfg_addr = 2'd1;
        cyc = 1;
        ready_viol = 0;
        to = 1'b0;
        while (done !== 1'b1) begin
            if (cfg_ready !== 1'b0) ready_viol++;
            if (cyc >= 40) begin to = 1'b1; break; end
            step();
            cyc++;
        end
        cfg_valid = 1'b0;
        n_cmp++; if (to || cyc != 9)      begin n_err++; $display("FAIL same_cycle_latency: got %0d cycles (timeout %0d), expected 9", cyc, to); end
        n_cmp++; if (ready_viol != 0)     begin n_err++; $display("FAIL cfg_ready_busy: got %0d cycles high, expected 0", ready_viol); end
        n_cmp++; if (cfg_ready !== 1'b0)  begin n_err++; $display("FAIL cfg_ready_done: got %b, expected 0", cfg_ready); end
        step();
        n_cmp++; if (spike_vec !== 4'b0100) begin n_err++; $display("FAIL same_cycle_spike: got %b, expected 0100", spike_vec); end
        n_cmp++; if (cfg_ready !== 1'b1)    begin n_err++; $display("FAIL cfg_ready_idle: got %b, expected 1", cfg_ready); end
        pulse_tick();
        wait_done(1, cyc, to);
        step();
        n_cmp++; if (spike_vec !== 4'b0000) begin n_err++; $display("FAIL busy_write_ignored: got %b, expected 0000", spike_vec); end
    endtask

    task automatic test_pending_overrun();
        int cyc;
        bit to;
        do_reset();
        pulse_tick();
        step();
        step();
        pulse_tick();
        wait_done(4, cyc, to);
        n_cmp++; if (to || cyc != 9) begin n_err++; $display("FAIL pending_first_done: got %0d cycles (timeout %0d), expected 9", cyc, to); end
        step();
        n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL pending_restart: got busy %b done %b, expected busy 1 done 0", busy, done); end
        wait_done(1, cyc, to);
        n_cmp++; if (to || cyc != 9) begin n_err++; $display("FAIL pending_second_done: got %0d cycles (timeout %0d), expected 9", cyc, to); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL pending_no_overrun: got %b, expected 0", overrun); end
        step();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL pending_back_idle: got busy %b, expected 0", busy); end
        // Three ticks in one sweep
        pulse_tick();
        pulse_tick();
        pulse_tick();
        wait_done(3, cyc, to);
        n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL overrun_set: got %b, expected 1", overrun); end
        step();
        wait_done(1, cyc, to);
        n_cmp++; if (to) begin n_err++; $display("FAIL overrun_second_sweep: got timeout, expected done"); end
        step();
        step();
        step();
        n_cmp++; if (busy !== 1'b0)    begin n_err++; $display("FAIL overrun_dropped: got busy %b, expected 0", busy); end
        n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL overrun_sticky: got %b, expected 1", overrun); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL overrun_clear: got %b, expected 0", overrun); end
    endtask

    task automatic test_rst_mid_sweep();
        int cyc;
        int done_seen;
        bit to;
        do_reset();
        cfg_write(2'd1, 8'd50);
        cfg_write(2'd3, 8'd255);
        pulse_tick();
        wait_done(1, cyc, to);
        step();
        n_cmp++; if (spike_vec !== 4'b1000) begin n_err++; $display("FAIL rst_setup_spike: got %b, expected 1000", spike_vec); end
        done_seen = 0;
        pulse_tick();
        for (int i = 0; i < 3; i++) begin
            if (done === 1'b1) done_seen++;
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL rst_mid_busy: got %b, expected 0", busy); end
        n_cmp++; if (done !== 1'b0)      begin n_err++; $display("FAIL rst_mid_done: got %b, expected 0", done); end
        n_cmp++; if (spike_vec !== '0)   begin n_err++; $display("FAIL rst_mid_spike_vec: got %b, expected 0", spike_vec); end
        n_cmp++; if (state_out !== 8'd0) begin n_err++; $display("FAIL rst_mid_state_out: got %0d, expected 0", state_out); end
        n_cmp++; if (overrun !== 1'b0)   begin n_err++; $display("FAIL rst_mid_overrun: got %b, expected 0", overrun); end
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1) done_seen++;
            step();
        end
        n_cmp++; if (done_seen != 0) begin n_err++; $display("FAIL rst_mid_no_done: got %0d pulses, expected 0", done_seen); end
        for (int i = 0; i < N; i++) begin
            sel = 2'(i);
            step();
            n_cmp++; if (state_out !== 8'd0) begin n_err++; $display("FAIL rst_mid_state[%0d]: got %0d, expected 0", i, state_out); end
        end
        // Stimuli were cleared too: a fresh sweep leaves everything at 0.
        pulse_tick();
        wait_done(1, cyc, to);
        step();
        n_cmp++; if (spike_vec !== '0) begin n_err++; $display("FAIL rst_mid_stim_spike: got %b, expected 0", spike_vec); end
        sel = 2'd1;
        step();
        n_cmp++; if (state_out !== 8'd0) begin n_err++; $display("FAIL rst_mid_stim_state1: got %0d, expected 0", state_out); end
    endtask

    task automatic test_random();
        int           cyc;
        bit           to;
        int           nwr;
        logic [1:0]   a;
        logic [7:0]   d;
        logic [N-1:0] exp_spk;
        do_reset();
        model_reset();
        for (int s = 0; s < 25; s++) begin
            nwr = $urandom_range(0, 2);
            for (int w = 0; w < nwr; w++) begin
                a = 2'($urandom_range(0, N - 1));
                d = 8'($urandom_range(0, 255));
                cfg_write(a, d);
                m_stim[a] = int'(d);
            end
            pulse_tick();
            wait_done(1, cyc, to);
            n_cmp++; if (to || cyc != 9) begin n_err++; $display("FAIL rand_latency[%0d]: got %0d cycles (timeout %0d), expected 9", s, cyc, to); end
            exp_spk = model_sweep();
            step();
            n_cmp++; if (spike_vec !== exp_spk) begin n_err++; $display("FAIL rand_spike[%0d]: got %b, expected %b", s, spike_vec, exp_spk); end
            for (int i = 0; i < N; i++) begin
                sel = 2'(i);
                step();
                n_cmp++; if (state_out !== 8'(m_state[i])) begin n_err++; $display("FAIL rand_state[%0d][%0d]: got %0d, expected %0d", s, i, state_out, m_state[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_charge_and_refractory();
        test_cfg_same_cycle();
        test_pending_overrun();
        test_rst_mid_sweep();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
